// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32M iterative divider: operation and state encodings
// plus the iteration-counter width helper.
package rv32i_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIN  = 2'b10
    } div_state_t;

    // Counter must hold N-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DIV_CNT_W = cnt_width(32);

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract the divisor
// magnitude and keep the difference when it is non-negative.
module div_step #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] part_rem,
    input  logic [N-1:0] part_quo,
    input  logic [N-1:0] dsr,
    output logic [N-1:0] next_rem,
    output logic [N-1:0] next_quo
);

    logic [N:0] shifted;
    logic [N:0] diff;

    always_comb begin
        shifted  = {part_rem, part_quo[N-1]};
        diff     = shifted - {1'b0, dsr};
        // diff[N] set means the trial subtraction went negative: restore.
        next_rem = diff[N] ? shifted[N-1:0] : diff[N-1:0];
        next_quo = {part_quo[N-2:0], ~diff[N]};
    end

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per clock.
// Define DIV_EARLY_OUT_EN to finish divide-by-zero and signed-overflow requests without RUN.
module div_unit
    import rv32i_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);

    localparam int unsigned CW = cnt_width(N);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_FIN  = ST_FIN;

    logic [1:0]    state_q, state_d;
    logic [1:0]    op_q;
    logic [N-1:0]  quo_q, rem_q, dsr_q, dvd_q, result_q, result_d;
    logic [CW-1:0] cnt_q;
    logic          q_neg_q, r_neg_q, divz_q, ovf_q;

    logic          accept, early_go, load_result, last_step;
    logic          is_signed, a_neg, b_neg, in_divz, in_ovf;
    logic [N-1:0]  a_mag, b_mag, step_rem, step_quo;

    function automatic logic [N-1:0] pick_result(
        input logic [1:0]   o,
        input logic [N-1:0] quo,
        input logic [N-1:0] rem,
        input logic         q_neg,
        input logic         r_neg,
        input logic         divz,
        input logic         ovf,
        input logic [N-1:0] dvd
    );
        logic [N-1:0] q, r;
        q = q_neg ? -quo : quo;
        r = r_neg ? -rem : rem;
        if (divz) begin
            q = '1;
            r = dvd;
        end else if (ovf) begin
            q = dvd;
            r = '0;
        end
        return o[1] ? r : q;
    endfunction

    always_comb begin
        is_signed = ~op[0];
        a_neg     = is_signed & dividend[N-1];
        b_neg     = is_signed & divisor[N-1];
        a_mag     = a_neg ? -dividend : dividend;
        b_mag     = b_neg ? -divisor : divisor;
        in_divz   = (divisor == '0);
        in_ovf    = is_signed && (dividend == {1'b1, {(N-1){1'b0}}}) && (&divisor);
        accept    = start && ((state_q == S_IDLE) || (state_q == S_FIN));
    end

`ifdef DIV_EARLY_OUT_EN
    assign early_go = accept & (in_divz | in_ovf);
`else
    assign early_go = 1'b0;
`endif

    div_step #(
        .N(N)
    ) u_step (
        .part_rem (rem_q),
        .part_quo (quo_q),
        .dsr      (dsr_q),
        .next_rem (step_rem),
        .next_quo (step_quo)
    );

    always_comb begin
        last_step   = (state_q == S_RUN) && (cnt_q == '0);
        load_result = last_step || early_go;
        state_d     = state_q;
        unique case (state_q)
            S_IDLE, S_FIN: begin
                if (early_go)    state_d = S_FIN;
                else if (accept) state_d = S_RUN;
                else             state_d = S_IDLE;
            end
            S_RUN:   if (last_step) state_d = S_FIN;
            default: state_d = S_IDLE;
        endcase
        if (early_go) begin
            result_d = pick_result(op, '0, '0, 1'b0, 1'b0, in_divz, in_ovf, dividend);
        end else begin
            result_d = pick_result(op_q, step_quo, step_rem, q_neg_q, r_neg_q,
                                   divz_q, ovf_q, dvd_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dsr_q    <= '0;
            dvd_q    <= '0;
            cnt_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            divz_q   <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= op;
                dvd_q   <= dividend;
                dsr_q   <= b_mag;
                quo_q   <= a_mag;
                rem_q   <= '0;
                cnt_q   <= CW'(N - 1);
                q_neg_q <= a_neg ^ b_neg;
                r_neg_q <= a_neg;
                divz_q  <= in_divz;
                ovf_q   <= in_ovf;
            end else if (state_q == S_RUN) begin
                quo_q <= step_quo;
                rem_q <= step_rem;
                cnt_q <= cnt_q - CW'(1);
            end
            if (load_result) result_q <= result_d;
        end
    end

    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_FIN);
    assign result = result_q;

endmodule
